// File: rtl/dpram_pkg.sv
// Shared types for the byte-enabled dual-port RAM with clear engine.
package dpram_pkg;

  // Same-port read-during-write behaviour: pre-write word or merged word.
  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_t;

  // Clear engine state: sweeping memory, or idle and serving users.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/dpram_clear_fsm.sv
// Clear engine: walks every word address once after reset or on request,
// raising busy and a write strobe for the top to steer into port A.
module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next-state logic: sweep to the last address then idle; a request restarts at 0.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        addr_d  = '0;
      end
    endcase
  end

  // State and address registers; reset always restarts a full sweep.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR) && reset_n;
  assign clr_addr = addr_q;

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with per-lane write enables, selectable output register,
// read-valid strobes, port-A-wins collision policy and a hardware clear engine.
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    OUT_REG     = 0,
  parameter rdw_mode_t             RDW_MODE    = RDW_OLD,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int                   NBE         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  ram_cs,
  input  logic                  ram_we,
  input  logic [NBE-1:0]        ram_be,
  input  logic [ADDR_WIDTH-1:0] ram_ad,
  input  logic [DATA_WIDTH-1:0] ram_d,
  output logic [DATA_WIDTH-1:0] ram_q,
  output logic                  ram_qv,
  input  logic                  ram_cs_b,
  input  logic                  ram_we_b,
  input  logic [NBE-1:0]        ram_be_b,
  input  logic [ADDR_WIDTH-1:0] ram_ad_b,
  input  logic [DATA_WIDTH-1:0] ram_d_b,
  output logic [DATA_WIDTH-1:0] ram_q_b,
  output logic                  ram_qv_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  acc_a, acc_b;
  logic                  wa_en, wb_en;
  logic [NBE-1:0]        wa_be, wb_be;
  logic [ADDR_WIDTH-1:0] wa_ad;
  logic [DATA_WIDTH-1:0] wa_d;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  logic [DATA_WIDTH-1:0] qa1_q, qa1_d, qa2_q, qa2_d;
  logic [DATA_WIDTH-1:0] qb1_q, qb1_d, qb2_q, qb2_d;
  logic                  qva1_q, qva1_d, qva2_q, qva2_d;
  logic                  qvb1_q, qvb1_d, qvb2_q, qvb2_d;

  dpram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Access gating, port A write-path mux (clear engine vs user), lane collision
  // masking for port B, and read data with optional same-port write merge.
  always_comb begin
    acc_a = ram_cs && !busy && reset_n;
    acc_b = ram_cs_b && !busy && reset_n;
    if (busy) begin
      wa_en = clr_we;
      wa_be = '1;
      wa_ad = clr_addr;
      wa_d  = CLEAR_VALUE;
    end else begin
      wa_en = acc_a && ram_we;
      wa_be = ram_be;
      wa_ad = ram_ad;
      wa_d  = ram_d;
    end
    wb_en = acc_b && ram_we_b;
    wb_be = ram_be_b;
    for (int i = 0; i < NBE; i++) begin
      if (wa_en && wa_be[i] && (wa_ad == ram_ad_b)) begin
        wb_be[i] = 1'b0;
      end
    end
    rd_a = mem[ram_ad];
    rd_b = mem[ram_ad_b];
    if (RDW_MODE == RDW_NEW) begin
      for (int i = 0; i < NBE; i++) begin
        if (ram_we && ram_be[i]) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = ram_d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (ram_we_b && ram_be_b[i]) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = ram_d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Lane-wise memory writes; port B lanes already claimed by port A are dropped.
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NBE; i++) begin
      if (wa_en && wa_be[i]) begin
        mem[wa_ad][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_d[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (wb_en && wb_be[i]) begin
        mem[ram_ad_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= ram_d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Output pipeline: stage 1 captures a completed read, stage 2 delays it once more.
  always_comb begin
    qa1_d  = acc_a ? rd_a : qa1_q;
    qb1_d  = acc_b ? rd_b : qb1_q;
    qva1_d = acc_a;
    qvb1_d = acc_b;
    qa2_d  = qva1_q ? qa1_q : qa2_q;
    qb2_d  = qvb1_q ? qb1_q : qb2_q;
    qva2_d = qva1_q;
    qvb2_d = qvb1_q;
  end

  // Output registers; only reset clears the held read data.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      qa1_q  <= '0;
      qb1_q  <= '0;
      qa2_q  <= '0;
      qb2_q  <= '0;
      qva1_q <= 1'b0;
      qvb1_q <= 1'b0;
      qva2_q <= 1'b0;
      qvb2_q <= 1'b0;
    end else begin
      qa1_q  <= qa1_d;
      qb1_q  <= qb1_d;
      qa2_q  <= qa2_d;
      qb2_q  <= qb2_d;
      qva1_q <= qva1_d;
      qvb1_q <= qvb1_d;
      qva2_q <= qva2_d;
      qvb2_q <= qvb2_d;
    end
  end

  assign ram_q    = (OUT_REG != 0) ? qa2_q  : qa1_q;
  assign ram_qv   = (OUT_REG != 0) ? qva2_q : qva1_q;
  assign ram_q_b  = (OUT_REG != 0) ? qb2_q  : qb1_q;
  assign ram_qv_b = (OUT_REG != 0) ? qvb2_q : qvb1_q;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench for dpram_be_clr: three instances share stimulus and differ
// only in read-during-write mode and output register depth.
module tb_dpram_be_clr;
  import dpram_pkg::*;

  localparam logic [15:0] CV = 16'h00A5;

  logic        clk_sys;
  logic        reset_n;
  logic        clear_req;
  logic        ram_cs, ram_we, ram_cs_b, ram_we_b;
  logic [1:0]  ram_be, ram_be_b;
  logic [3:0]  ram_ad, ram_ad_b;
  logic [15:0] ram_d, ram_d_b;

  logic        busy_old, busy_new, busy_pipe;
  logic [15:0] q_old, q_b_old, q_new, q_b_new, q_pipe, q_b_pipe;
  logic        qv_old, qv_b_old, qv_new, qv_b_new, qv_pipe, qv_b_pipe;

  int n_checks;
  int n_fail;
  int n;

  dpram_be_clr #(
    .DATA_WIDTH (16), .ADDR_WIDTH (4), .BYTE_WIDTH (8), .OUT_REG (0),
    .RDW_MODE (RDW_OLD), .CLEAR_VALUE (CV)
  ) u_old (
    .clk_sys (clk_sys), .reset_n (reset_n), .clear_req (clear_req), .busy (busy_old),
    .ram_cs (ram_cs), .ram_we (ram_we), .ram_be (ram_be), .ram_ad (ram_ad),
    .ram_d (ram_d), .ram_q (q_old), .ram_qv (qv_old),
    .ram_cs_b (ram_cs_b), .ram_we_b (ram_we_b), .ram_be_b (ram_be_b), .ram_ad_b (ram_ad_b),
    .ram_d_b (ram_d_b), .ram_q_b (q_b_old), .ram_qv_b (qv_b_old)
  );

  dpram_be_clr #(
    .DATA_WIDTH (16), .ADDR_WIDTH (4), .BYTE_WIDTH (8), .OUT_REG (0),
    .RDW_MODE (RDW_NEW), .CLEAR_VALUE (CV)
  ) u_new (
    .clk_sys (clk_sys), .reset_n (reset_n), .clear_req (clear_req), .busy (busy_new),
    .ram_cs (ram_cs), .ram_we (ram_we), .ram_be (ram_be), .ram_ad (ram_ad),
    .ram_d (ram_d), .ram_q (q_new), .ram_qv (qv_new),
    .ram_cs_b (ram_cs_b), .ram_we_b (ram_we_b), .ram_be_b (ram_be_b), .ram_ad_b (ram_ad_b),
    .ram_d_b (ram_d_b), .ram_q_b (q_b_new), .ram_qv_b (qv_b_new)
  );

  dpram_be_clr #(
    .DATA_WIDTH (16), .ADDR_WIDTH (4), .BYTE_WIDTH (8), .OUT_REG (1),
    .RDW_MODE (RDW_OLD), .CLEAR_VALUE (CV)
  ) u_pipe (
    .clk_sys (clk_sys), .reset_n (reset_n), .clear_req (clear_req), .busy (busy_pipe),
    .ram_cs (ram_cs), .ram_we (ram_we), .ram_be (ram_be), .ram_ad (ram_ad),
    .ram_d (ram_d), .ram_q (q_pipe), .ram_qv (qv_pipe),
    .ram_cs_b (ram_cs_b), .ram_we_b (ram_we_b), .ram_be_b (ram_be_b), .ram_ad_b (ram_ad_b),
    .ram_d_b (ram_d_b), .ram_q_b (q_b_pipe), .ram_qv_b (qv_b_pipe)
  );

  // Free-running 100 MHz system clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drive both ports for one cycle and step past the sampling edge.
  task automatic applyStimulus(input logic cs, input logic we, input logic [1:0] be,
                               input logic [3:0] ad, input logic [15:0] d,
                               input logic cs_b, input logic we_b, input logic [1:0] be_b,
                               input logic [3:0] ad_b, input logic [15:0] d_b);
    ram_cs   = cs;
    ram_we   = we;
    ram_be   = be;
    ram_ad   = ad;
    ram_d    = d;
    ram_cs_b = cs_b;
    ram_we_b = we_b;
    ram_be_b = be_b;
    ram_ad_b = ad_b;
    ram_d_b  = d_b;
    tick();
  endtask

  // One immediate-assertion comparison point.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    clear_req = 1'b0;
    ram_cs = 0; ram_we = 0; ram_be = 0; ram_ad = 0; ram_d = 0;
    ram_cs_b = 0; ram_we_b = 0; ram_be_b = 0; ram_ad_b = 0; ram_d_b = 0;

    // Reset state held for three cycles.
    repeat (3) tick();
    checkOutput("reset_busy", {15'd0, busy_old}, 16'd1);
    checkOutput("reset_q", q_old, 16'h0000);
    checkOutput("reset_qv", {15'd0, qv_old}, 16'd0);
    checkOutput("reset_q_pipe", q_pipe, 16'h0000);
    checkOutput("reset_qv_b", {15'd0, qv_b_old}, 16'd0);

    // Initial clear lasts exactly 16 cycles after release.
    reset_n = 1'b1;
    n = 0;
    while (busy_old && n < 40) begin
      tick();
      n++;
    end
    checkOutput("clear_len", n[15:0], 16'd16);
    checkOutput("clear_len_pipe", {15'd0, busy_pipe}, 16'd0);

    // Every address reads CLEAR_VALUE with a valid strobe one cycle later.
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1, 0, 2'b00, a[3:0], 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
      checkOutput($sformatf("clr_rd_q_%0d", a), q_old, CV);
      checkOutput($sformatf("clr_rd_qv_%0d", a), {15'd0, qv_old}, 16'd1);
    end
    applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("idle_qv", {15'd0, qv_old}, 16'd0);
    checkOutput("idle_q_hold", q_old, CV);

    // Byte enables on address 3.
    applyStimulus(1, 1, 2'b11, 4'h3, 16'h1234, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("be_wr1_old", q_old, CV);
    checkOutput("be_wr1_new", q_new, 16'h1234);
    applyStimulus(1, 1, 2'b01, 4'h3, 16'hABCD, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("be_wr2_old", q_old, 16'h1234);
    checkOutput("be_wr2_new", q_new, 16'h12CD);
    applyStimulus(1, 0, 2'b00, 4'h3, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("be_rd", q_old, 16'h12CD);
    applyStimulus(1, 1, 2'b00, 4'h3, 16'hFFFF, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("be0_rd_new", q_new, 16'h12CD);
    applyStimulus(1, 0, 2'b00, 4'h3, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("be0_nowrite", q_old, 16'h12CD);

    // Same-address collision on address 5.
    applyStimulus(1, 1, 2'b11, 4'h5, 16'h1111, 1, 1, 2'b11, 4'h5, 16'h2222);
    checkOutput("coll_b_old", q_b_old, CV);
    applyStimulus(1, 0, 2'b00, 4'h5, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("coll_full", q_old, 16'h1111);
    applyStimulus(1, 1, 2'b01, 4'h5, 16'h1111, 1, 1, 2'b11, 4'h5, 16'h2222);
    applyStimulus(1, 0, 2'b00, 4'h5, 16'h0, 1, 0, 2'b00, 4'h5, 16'h0);
    checkOutput("coll_part_a", q_old, 16'h2211);
    checkOutput("coll_part_b", q_b_old, 16'h2211);

    // Read-during-write on address 7 with a port B read in the same cycle.
    applyStimulus(1, 1, 2'b11, 4'h7, 16'h0000, 0, 0, 2'b00, 4'h0, 16'h0);
    applyStimulus(1, 1, 2'b11, 4'h7, 16'h005A, 1, 0, 2'b00, 4'h7, 16'h0);
    checkOutput("rdw_old_q", q_old, 16'h0000);
    checkOutput("rdw_old_qv", {15'd0, qv_old}, 16'd1);
    checkOutput("rdw_new_q", q_new, 16'h005A);
    checkOutput("rdw_new_qv", {15'd0, qv_new}, 16'd1);
    checkOutput("rdw_cross_old", q_b_old, 16'h0000);
    checkOutput("rdw_cross_new", q_b_new, 16'h0000);
    checkOutput("rdw_cross_qv", {15'd0, qv_b_old}, 16'd1);
    applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 1, 0, 2'b00, 4'h7, 16'h0);
    checkOutput("cross_visible", q_b_old, 16'h005A);

    // Output-register pipeline on addresses 0..2.
    applyStimulus(1, 1, 2'b11, 4'h0, 16'h1000, 0, 0, 2'b00, 4'h0, 16'h0);
    applyStimulus(1, 1, 2'b11, 4'h1, 16'h1001, 0, 0, 2'b00, 4'h0, 16'h0);
    applyStimulus(1, 1, 2'b11, 4'h2, 16'h1002, 0, 0, 2'b00, 4'h0, 16'h0);
    repeat (3) applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_idle_qv", {15'd0, qv_pipe}, 16'd0);
    applyStimulus(1, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_lat_qv", {15'd0, qv_pipe}, 16'd0);
    checkOutput("nopipe_q0", q_old, 16'h1000);
    applyStimulus(1, 0, 2'b00, 4'h1, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_q0", q_pipe, 16'h1000);
    checkOutput("pipe_qv0", {15'd0, qv_pipe}, 16'd1);
    applyStimulus(1, 0, 2'b00, 4'h2, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_q1", q_pipe, 16'h1001);
    checkOutput("pipe_qv1", {15'd0, qv_pipe}, 16'd1);
    applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_q2", q_pipe, 16'h1002);
    checkOutput("pipe_qv2", {15'd0, qv_pipe}, 16'd1);
    applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("pipe_qv_end", {15'd0, qv_pipe}, 16'd0);
    checkOutput("pipe_q_hold", q_pipe, 16'h1002);

    // Clear request with an in-flight read of address 3.
    clear_req = 1'b1;
    applyStimulus(1, 0, 2'b00, 4'h3, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    clear_req = 1'b0;
    checkOutput("req_busy", {15'd0, busy_old}, 16'd1);
    checkOutput("req_inflight", q_old, 16'h12CD);

    // User writes while busy, then reset mid-clear.
    repeat (4) begin
      applyStimulus(1, 1, 2'b11, 4'h8, 16'h7777, 1, 1, 2'b11, 4'h9, 16'h8888);
      checkOutput("busy_qv", {15'd0, qv_old}, 16'd0);
      checkOutput("busy_qv_b", {15'd0, qv_b_old}, 16'd0);
    end
    reset_n = 1'b0;
    repeat (2) tick();
    checkOutput("midrst_busy", {15'd0, busy_old}, 16'd1);
    checkOutput("midrst_q", q_old, 16'h0000);
    reset_n = 1'b1;
    n = 0;
    while (busy_old && n < 40) begin
      tick();
      n++;
    end
    checkOutput("reclear_len", n[15:0], 16'd16);
    applyStimulus(1, 0, 2'b00, 4'h8, 16'h0, 1, 0, 2'b00, 4'h9, 16'h0);
    checkOutput("busywr_a", q_old, CV);
    checkOutput("busywr_b", q_b_old, CV);
    applyStimulus(1, 0, 2'b00, 4'h3, 16'h0, 1, 0, 2'b00, 4'h7, 16'h0);
    checkOutput("recleared_a", q_old, CV);
    checkOutput("recleared_b", q_b_old, CV);
    checkOutput("recleared_new", q_new, CV);
    applyStimulus(0, 0, 2'b00, 4'h0, 16'h0, 0, 0, 2'b00, 4'h0, 16'h0);
    checkOutput("final_busy_new", {15'd0, busy_new}, 16'd0);
    checkOutput("final_qv_b_new", {15'd0, qv_b_new}, 16'd0);
    checkOutput("final_q_b_pipe", q_b_pipe, CV);
    checkOutput("final_qv_b_pipe", {15'd0, qv_b_pipe}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
